// File: rtl/fft_pkg.sv
// Shared FFT front-end constants and the input arbiter state encoding.
// Arbiter state values double as the one-hot o_grant code (IDLE = 00).
package fft_pkg;

    localparam int NB_DATA_DEF  = 16;
    localparam int N_POINT_DEF  = 16;
    localparam int NB_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/fft_input_arbiter_if.sv
// AXI-Stream bundle used for both arbiter inputs and the FFT-facing output.
// Handshake: a beat transfers on a rising edge where tvalid and tready are both 1;
// the master holds tdata/tlast stable while tvalid=1 and tready=0.
interface fft_input_arbiter_if #(
    parameter int NB_DATA = fft_pkg::NB_DATA_DEF
) ();

    logic               tvalid;
    logic [NB_DATA-1:0] tdata;
    logic               tlast;
    logic               tready;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/axis_out_reg.sv
// Single-entry registered AXI-Stream stage; can take a new beat whenever it is
// empty or its current beat leaves in the same cycle.
module axis_out_reg #(
    parameter int NB_DATA = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_last,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_last,
    output logic               o_can_load
);

    logic               valid_q;
    logic [NB_DATA-1:0] data_q;
    logic               last_q;

    assign o_can_load = !valid_q || i_ready;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_last     = last_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (i_load) begin
            valid_q <= 1'b1;
            data_q  <= i_data;
            last_q  <= i_last;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_input_arbiter.sv
// Frame-granular round-robin arbiter in front of the FFT input: one source owns
// exactly N_POINT beats, and output tlast comes from the local beat counter.
module fft_input_arbiter
    import fft_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int N_POINT  = N_POINT_DEF,
    parameter int NB_COUNT = NB_COUNT_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_hold,
    fft_input_arbiter_if.slave         s0_axis,
    fft_input_arbiter_if.slave         s1_axis,
    fft_input_arbiter_if.master        m_axis,
    output logic [1:0]                 o_grant,
    output logic                       o_len_err
);

    localparam logic [NB_COUNT-1:0] LAST_BEAT = NB_COUNT'(N_POINT - 1);

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic                last_q;
    logic [NB_COUNT-1:0] cnt_q;
    logic                len_err_q;

    logic                out_can_load;
    logic                acc0;
    logic                acc1;
    logic                accept;
    logic                at_last;
    logic [NB_DATA-1:0]  acc_data;
    logic                acc_tlast_in;

    // Only the owning source sees ready; it mirrors the output stage's room.
    assign s0_axis.tready = (state_q == ST_GRANT0) && out_can_load;
    assign s1_axis.tready = (state_q == ST_GRANT1) && out_can_load;

    assign acc0         = s0_axis.tvalid && s0_axis.tready;
    assign acc1         = s1_axis.tvalid && s1_axis.tready;
    assign accept       = acc0 || acc1;
    assign at_last      = (cnt_q == LAST_BEAT);
    assign acc_data     = (state_q == ST_GRANT1) ? s1_axis.tdata : s0_axis.tdata;
    assign acc_tlast_in = (state_q == ST_GRANT1) ? s1_axis.tlast : s0_axis.tlast;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!i_hold) begin
                    // last_q names the previous owner; the other side wins a tie.
                    if (s0_axis.tvalid && s1_axis.tvalid) begin
                        state_d = last_q ? ST_GRANT0 : ST_GRANT1;
                    end else if (s0_axis.tvalid) begin
                        state_d = ST_GRANT0;
                    end else if (s1_axis.tvalid) begin
                        state_d = ST_GRANT1;
                    end
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (accept && at_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_err_q <= accept && (acc_tlast_in != at_last);
            if (accept) begin
                cnt_q <= at_last ? '0 : cnt_q + 1'b1;
                if (at_last) begin
                    last_q <= (state_q == ST_GRANT1);
                end
            end
        end
    end

    axis_out_reg #(
        .NB_DATA (NB_DATA)
    ) u_out_reg (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (accept),
        .i_data     (acc_data),
        .i_last     (at_last),
        .i_ready    (m_axis.tready),
        .o_valid    (m_axis.tvalid),
        .o_data     (m_axis.tdata),
        .o_last     (m_axis.tlast),
        .o_can_load (out_can_load)
    );

    assign o_grant   = state_q;
    assign o_len_err = len_err_q;

endmodule

// File: tb/tb_fft_input_arbiter.sv
// Directed bench for fft_input_arbiter: per-scenario tasks with inline checks
// against hand-built expected beat queues.
module tb_fft_input_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hold;
    logic [1:0] grant;
    logic       len_err;

    fft_input_arbiter_if #(.NB_DATA(16)) s0_if ();
    fft_input_arbiter_if #(.NB_DATA(16)) s1_if ();
    fft_input_arbiter_if #(.NB_DATA(16)) m_if ();

    fft_input_arbiter #(
        .NB_DATA  (16),
        .N_POINT  (16),
        .NB_COUNT (4)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_hold    (hold),
        .s0_axis   (s0_if),
        .s1_axis   (s1_if),
        .m_axis    (m_if),
        .o_grant   (grant),
        .o_len_err (len_err)
    );

    always #5 clk = ~clk;

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];
    logic [1:0]  grant_log[$];
    logic [16:0] prev_out;
    bit          en0, en1, rdy_toggle, rst_v, hold_v;
    bit          acc0, acc1, prev_stall;
    int          len_err_cnt, stall_viol, acc0_cnt, acc1_cnt;
    int          n_pass, n_total;

    // One bus cycle: drive at the falling edge, sample 2ns later.
    task automatic step();
        @(negedge clk);
        if (acc0 && q0.size() != 0) void'(q0.pop_front());
        if (acc1 && q1.size() != 0) void'(q1.pop_front());
        rst_n = rst_v;
        hold  = hold_v;
        s0_if.tvalid = en0 && (q0.size() != 0);
        if (s0_if.tvalid) {s0_if.tlast, s0_if.tdata} = q0[0];
        else {s0_if.tlast, s0_if.tdata} = 17'h0;
        s1_if.tvalid = en1 && (q1.size() != 0);
        if (s1_if.tvalid) {s1_if.tlast, s1_if.tdata} = q1[0];
        else {s1_if.tlast, s1_if.tdata} = 17'h0;
        m_if.tready = rdy_toggle ? ~m_if.tready : 1'b1;
        #2;
        if (prev_stall && rst_n &&
            (m_if.tvalid !== 1'b1 || {m_if.tlast, m_if.tdata} !== prev_out))
            stall_viol++;
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_out   = {m_if.tlast, m_if.tdata};
        acc0 = s0_if.tvalid && s0_if.tready && rst_n;
        acc1 = s1_if.tvalid && s1_if.tready && rst_n;
        if (acc0) acc0_cnt++;
        if (acc1) acc1_cnt++;
        if (m_if.tvalid && m_if.tready) got_q.push_back({m_if.tlast, m_if.tdata});
        if (len_err === 1'b1) len_err_cnt++;
        grant_log.push_back(grant);
    endtask

    task automatic do_reset();
        en0 = 0; en1 = 0; hold_v = 0; rdy_toggle = 0; rst_v = 0;
        step();
        step();
        q0.delete(); q1.delete(); got_q.delete(); exp_q.delete(); grant_log.delete();
        acc0 = 0; acc1 = 0; prev_stall = 0;
        len_err_cnt = 0; stall_viol = 0; acc0_cnt = 0; acc1_cnt = 0;
        rst_v = 1;
        step();
    endtask

    task automatic test_reset();
        rst_v = 0; en0 = 1; en1 = 1;
        q0.push_back(17'h00123);
        q1.push_back(17'h00456);
        step();
        step();
        n_total++; if (m_if.tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid); else n_pass++;
        n_total++; if (m_if.tdata !== 16'h0) $display("FAIL reset_tdata: got %h want 0000", m_if.tdata); else n_pass++;
        n_total++; if (m_if.tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", m_if.tlast); else n_pass++;
        n_total++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else n_pass++;
        n_total++; if (len_err !== 1'b0) $display("FAIL reset_len_err: got %b want 0", len_err); else n_pass++;
        n_total++; if (s0_if.tready !== 1'b0) $display("FAIL reset_s0_tready: got %b want 0", s0_if.tready); else n_pass++;
        n_total++; if (s1_if.tready !== 1'b0) $display("FAIL reset_s1_tready: got %b want 0", s1_if.tready); else n_pass++;
    endtask

    task automatic test_single_source();
        logic [16:0] act;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            q0.push_back({i == 15, 16'(i)});
            exp_q.push_back({i == 15, 16'(i)});
        end
        en0 = 1;
        step();
        n_total++; if (grant !== 2'b00 || s0_if.tready !== 1'b0)
            $display("FAIL single_req_cycle: got grant=%b tready=%b want 00/0", grant, s0_if.tready); else n_pass++;
        step();
        n_total++; if (grant !== 2'b01 || s0_if.tready !== 1'b1 || m_if.tvalid !== 1'b0)
            $display("FAIL single_grant_cycle: got grant=%b tready=%b mvalid=%b want 01/1/0", grant, s0_if.tready, m_if.tvalid); else n_pass++;
        step();
        n_total++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'h0000)
            $display("FAIL single_first_out: got valid=%b data=%h want 1/0000", m_if.tvalid, m_if.tdata); else n_pass++;
        for (int c = 0; c < 40 && got_q.size() < 16; c++) step();
        n_total++; if (got_q.size() != 16) $display("FAIL single_count: got %0d want 16", got_q.size()); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            act = (i < got_q.size()) ? got_q[i] : 17'bx;
            n_total++; if (act !== exp_q[i]) $display("FAIL single_beat%0d: got %h want %h", i, act, exp_q[i]); else n_pass++;
        end
        step();
        n_total++; if (grant !== 2'b00) $display("FAIL single_idle_after: got %b want 00", grant); else n_pass++;
        n_total++; if (len_err_cnt != 0) $display("FAIL single_len_err: got %0d want 0", len_err_cnt); else n_pass++;
    endtask

    task automatic test_alternate();
        logic [16:0] act;
        int f, l, zeros, ones;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            q0.push_back({(i % 16) == 15, 16'h2000 + 16'(i)});
            q1.push_back({(i % 16) == 15, 16'h3000 + 16'(i)});
        end
        for (int fr = 0; fr < 4; fr++)
            for (int i = 0; i < 16; i++)
                exp_q.push_back({i == 15, ((fr % 2) == 0 ? 16'h2000 : 16'h3000) + 16'((fr / 2) * 16 + i)});
        en0 = 1; en1 = 1;
        for (int c = 0; c < 200 && got_q.size() < 64; c++) step();
        n_total++; if (got_q.size() != 64) $display("FAIL alt_count: got %0d want 64", got_q.size()); else n_pass++;
        for (int i = 0; i < 64; i++) begin
            act = (i < got_q.size()) ? got_q[i] : 17'bx;
            n_total++; if (act !== exp_q[i]) $display("FAIL alt_beat%0d: got %h want %h", i, act, exp_q[i]); else n_pass++;
        end
        f = -1; l = -1; zeros = 0; ones = 0;
        for (int i = 0; i < grant_log.size(); i++)
            if (grant_log[i] != 2'b00) begin
                if (f < 0) f = i;
                l = i;
            end
        for (int i = 0; i < grant_log.size(); i++)
            if (f >= 0 && i >= f && i <= l) begin
                if (grant_log[i] == 2'b00) zeros++;
                else ones++;
            end
        n_total++; if (ones != 64) $display("FAIL alt_grant_cycles: got %0d want 64", ones); else n_pass++;
        n_total++; if (zeros != 3) $display("FAIL alt_idle_gaps: got %0d want 3", zeros); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [16:0] act;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            q0.push_back({i == 15, 16'h4A00 + 16'(i)});
            exp_q.push_back({i == 15, 16'h4A00 + 16'(i)});
        end
        en0 = 1; rdy_toggle = 1;
        for (int c = 0; c < 100 && got_q.size() < 16; c++) step();
        rdy_toggle = 0;
        step();
        step();
        n_total++; if (got_q.size() != 16) $display("FAIL bp_count: got %0d want 16", got_q.size()); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            act = (i < got_q.size()) ? got_q[i] : 17'bx;
            n_total++; if (act !== exp_q[i]) $display("FAIL bp_beat%0d: got %h want %h", i, act, exp_q[i]); else n_pass++;
        end
        n_total++; if (stall_viol != 0) $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol); else n_pass++;
        n_total++; if (grant !== 2'b00) $display("FAIL bp_idle_after: got %b want 00", grant); else n_pass++;
    endtask

    task automatic test_len_err();
        logic [16:0] act;
        int grant0_seen;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            q1.push_back({(i == 9) || (i == 15), 16'h5B00 + 16'(i)});
            exp_q.push_back({i == 15, 16'h5B00 + 16'(i)});
        end
        en1 = 1;
        for (int c = 0; c < 60 && got_q.size() < 16; c++) step();
        step();
        step();
        n_total++; if (len_err_cnt != 1) $display("FAIL lerr_early_pulses: got %0d want 1", len_err_cnt); else n_pass++;
        n_total++; if (got_q.size() != 16) $display("FAIL lerr_count: got %0d want 16", got_q.size()); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            act = (i < got_q.size()) ? got_q[i] : 17'bx;
            n_total++; if (act !== exp_q[i]) $display("FAIL lerr_beat%0d: got %h want %h", i, act, exp_q[i]); else n_pass++;
        end
        grant0_seen = 0;
        foreach (grant_log[i]) if (grant_log[i] == 2'b01) grant0_seen++;
        n_total++; if (grant0_seen != 0) $display("FAIL lerr_wrong_owner: got %0d cycles of 01 want 0", grant0_seen); else n_pass++;
        // Second frame: tlast missing on the final beat.
        got_q.delete(); len_err_cnt = 0;
        for (int i = 0; i < 16; i++) q1.push_back({1'b0, 16'h5C00 + 16'(i)});
        for (int c = 0; c < 60 && got_q.size() < 16; c++) step();
        step();
        step();
        n_total++; if (len_err_cnt != 1) $display("FAIL lerr_missing_pulses: got %0d want 1", len_err_cnt); else n_pass++;
        act = (got_q.size() == 16) ? got_q[15] : 17'bx;
        n_total++; if (act !== 17'h15C0F) $display("FAIL lerr_missing_tlast: got %h want 15c0f", act); else n_pass++;
    endtask

    task automatic test_hold();
        logic [16:0] act;
        do_reset();
        for (int i = 0; i < 32; i++) q0.push_back({(i % 16) == 15, 16'h6C00 + 16'(i)});
        for (int i = 0; i < 16; i++) exp_q.push_back({i == 15, 16'h6C00 + 16'(i)});
        en0 = 1;
        for (int c = 0; c < 30 && acc0_cnt < 5; c++) step();
        hold_v = 1;
        for (int c = 0; c < 40 && got_q.size() < 16; c++) step();
        n_total++; if (got_q.size() != 16) $display("FAIL hold_count: got %0d want 16", got_q.size()); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            act = (i < got_q.size()) ? got_q[i] : 17'bx;
            n_total++; if (act !== exp_q[i]) $display("FAIL hold_beat%0d: got %h want %h", i, act, exp_q[i]); else n_pass++;
        end
        for (int c = 0; c < 4; c++) begin
            step();
            n_total++; if (grant !== 2'b00) $display("FAIL hold_no_grant%0d: got %b want 00", c, grant); else n_pass++;
        end
        n_total++; if (acc0_cnt != 16) $display("FAIL hold_accepts: got %0d want 16", acc0_cnt); else n_pass++;
        hold_v = 0;
        step();
        n_total++; if (grant !== 2'b00) $display("FAIL hold_release_cycle: got %b want 00", grant); else n_pass++;
        step();
        n_total++; if (grant !== 2'b01) $display("FAIL hold_resume: got %b want 01", grant); else n_pass++;
        for (int c = 0; c < 40 && got_q.size() < 32; c++) step();
        n_total++; if (got_q.size() != 32) $display("FAIL hold_second_frame: got %0d want 32", got_q.size()); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [16:0] act;
        int tl;
        do_reset();
        for (int i = 0; i < 16; i++) q0.push_back({i == 15, 16'h7D00 + 16'(i)});
        en0 = 1;
        for (int c = 0; c < 30 && acc0_cnt < 7; c++) step();
        rst_v = 0;
        step();
        step();
        n_total++; if (m_if.tvalid !== 1'b0) $display("FAIL mrst_tvalid: got %b want 0", m_if.tvalid); else n_pass++;
        n_total++; if (m_if.tdata !== 16'h0) $display("FAIL mrst_tdata: got %h want 0000", m_if.tdata); else n_pass++;
        n_total++; if (m_if.tlast !== 1'b0) $display("FAIL mrst_tlast: got %b want 0", m_if.tlast); else n_pass++;
        n_total++; if (grant !== 2'b00) $display("FAIL mrst_grant: got %b want 00", grant); else n_pass++;
        n_total++; if (s0_if.tready !== 1'b0) $display("FAIL mrst_tready: got %b want 0", s0_if.tready); else n_pass++;
        tl = 0;
        foreach (got_q[i]) if (got_q[i][16]) tl++;
        n_total++; if (tl != 0) $display("FAIL mrst_tlast_seen: got %0d want 0", tl); else n_pass++;
        q0.delete(); q1.delete(); got_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            q0.push_back({i == 15, 16'h7E00 + 16'(i)});
            q1.push_back({i == 15, 16'h8E00 + 16'(i)});
            exp_q.push_back({i == 15, 16'h7E00 + 16'(i)});
        end
        en1 = 1;
        rst_v = 1;
        for (int c = 0; c < 60 && got_q.size() < 16; c++) step();
        n_total++; if (got_q.size() < 16) $display("FAIL mrst_count: got %0d want 16", got_q.size()); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            act = (i < got_q.size()) ? got_q[i] : 17'bx;
            n_total++; if (act !== exp_q[i]) $display("FAIL mrst_beat%0d: got %h want %h", i, act, exp_q[i]); else n_pass++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; hold = 1'b0;
        s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0;
        s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0;
        m_if.tready = 1'b1;
        en0 = 0; en1 = 0; rdy_toggle = 0; rst_v = 0; hold_v = 0;
        acc0 = 0; acc1 = 0; prev_stall = 0; prev_out = '0;
        len_err_cnt = 0; stall_viol = 0; acc0_cnt = 0; acc1_cnt = 0;
        test_reset();
        test_single_source();
        test_alternate();
        test_backpressure();
        test_len_err();
        test_hold();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
